// File: rtl/pac_motion_if.sv
// pac_motion_if: PS/2 byte input, maze-map lookup and sprite placement signals of the Pac motion controller
interface pac_motion_if;
  logic [7:0] i_ps2_byte;
  logic       i_ps2_ready;
  logic [8:0] o_map_addr;
  logic       i_map_wall;
  logic [9:0] o_pac_x;
  logic [8:0] o_pac_y;
  logic [1:0] o_facing;
  logic       o_moving;
  logic       o_step;
  logic       o_bump;
  modport master (
    output i_ps2_byte, i_ps2_ready, i_map_wall,
    input  o_map_addr, o_pac_x, o_pac_y, o_facing, o_moving, o_step, o_bump
  );
  modport slave (
    input  i_ps2_byte, i_ps2_ready, i_map_wall,
    output o_map_addr, o_pac_x, o_pac_y, o_facing, o_moving, o_step, o_bump
  );
endinterface

// File: rtl/pac_motion_ctrl.sv
// pac_motion_ctrl: arrow-key decoder and tile-grid stepper with maze wall lookup for the Pac sprite
module pac_motion_ctrl #(
  parameter int STEP_DIV  = 12_500_000,
  parameter int START_COL = 10,
  parameter int START_ROW = 7
) (
  input logic         clk,
  input logic         rst_n,
  pac_motion_if.slave bus
);
  localparam int CW = $clog2(STEP_DIV);
  typedef enum logic [1:0] {IDLE, LOOKUP, CHECK} state_t;
  state_t          r_state, w_next;
  logic            r_rdy, w_stb;
  logic            r_ext, r_brk, r_valid;
  logic [1:0]      r_facing, w_code;
  logic            w_arrow;
  logic [CW-1:0]   r_cnt;
  logic            w_tick;
  logic [4:0]      w_col, w_tcol, r_tcol;
  logic [3:0]      w_row, w_trow, r_trow;
  logic [8:0]      w_taddr, r_addr;
  logic [9:0]      r_px;
  logic [8:0]      r_py;
  logic            w_edge, w_launch, w_step, w_bump, r_step, r_bump;
  // delayed copy of ps2_ready so its rising edge yields a one-cycle byte strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rdy <= 1'b0;
    else r_rdy <= bus.i_ps2_ready;
  assign w_stb = bus.i_ps2_ready & ~r_rdy;
  // map extended arrow codes onto the facing encoding (up, down, left, right)
  always_comb begin
    w_arrow = 1'b1;
    w_code  = 2'b00;
    case (bus.i_ps2_byte)
      8'h75:   w_code = 2'b00;
      8'h72:   w_code = 2'b01;
      8'h6B:   w_code = 2'b10;
      8'h74:   w_code = 2'b11;
      default: w_arrow = 1'b0;
    endcase
  end
  // make/break decoder; the held direction and facing share one register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_valid  <= 1'b0;
      r_facing <= 2'b10;
    end else if (w_stb) begin
      if (bus.i_ps2_byte == 8'hE0) r_ext <= 1'b1;
      else if (bus.i_ps2_byte == 8'hF0) r_brk <= 1'b1;
      else begin
        if (r_ext && w_arrow && !r_brk) begin
          r_facing <= w_code;
          r_valid  <= 1'b1;
        end else if (r_ext && w_arrow && w_code == r_facing) r_valid <= 1'b0;
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  // free-running step divider
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
  assign w_tick = r_cnt == CW'(STEP_DIV - 1);
  assign w_col   = r_px[9:5];
  assign w_row   = r_py[8:5];
  assign w_tcol  = r_facing == 2'b10 ? w_col - 5'd1 : r_facing == 2'b11 ? w_col + 5'd1 : w_col;
  assign w_trow  = r_facing == 2'b00 ? w_row - 4'd1 : r_facing == 2'b01 ? w_row + 4'd1 : w_row;
  assign w_edge  = r_facing == 2'b00 ? w_row == 4'd0 : r_facing == 2'b01 ? w_row == 4'd14 :
                   r_facing == 2'b10 ? w_col == 5'd0 : w_col == 5'd19;
  assign w_taddr = {1'b0, w_trow, 4'b0} + {3'b0, w_trow, 2'b0} + {4'b0, w_tcol};
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // FSM next state: a lookup always takes exactly IDLE -> LOOKUP -> CHECK -> IDLE
  always_comb
    w_next = r_state == IDLE ? (w_launch ? LOOKUP : IDLE) : r_state == LOOKUP ? CHECK : IDLE;
  // FSM outputs: edge refusals resolve in IDLE, wall refusals in CHECK
  always_comb begin
    w_launch = r_state == IDLE && w_tick && r_valid && !w_edge;
    w_bump   = (r_state == IDLE && w_tick && r_valid && w_edge) || (r_state == CHECK && bus.i_map_wall);
    w_step   = r_state == CHECK && !bus.i_map_wall;
  end
  // latch the target tile on launch and commit it as pixel position when the tile is open
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tcol <= '0;
      r_trow <= '0;
      r_addr <= '0;
      r_px   <= 10'(START_COL * 32);
      r_py   <= 9'(START_ROW * 32);
      r_step <= 1'b0;
      r_bump <= 1'b0;
    end else begin
      r_step <= w_step;
      r_bump <= w_bump;
      if (w_launch) begin
        r_tcol <= w_tcol;
        r_trow <= w_trow;
        r_addr <= w_taddr;
      end
      if (w_step) begin
        r_px <= {r_tcol, 5'b0};
        r_py <= {r_trow, 5'b0};
      end
    end
  assign bus.o_map_addr = r_addr;
  assign bus.o_pac_x    = r_px;
  assign bus.o_pac_y    = r_py;
  assign bus.o_facing   = r_facing;
  assign bus.o_moving   = r_valid;
  assign bus.o_step     = r_step;
  assign bus.o_bump     = r_bump;
endmodule

// File: tb/tb_pac_motion_ctrl.sv
// tb_pac_motion_ctrl: directed checks of key decoding, stepping, wall/edge refusal and reset mid-lookup
module tb_pac_motion_ctrl;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  pac_motion_if if_a ();
  pac_motion_if if_b ();
  pac_motion_ctrl #(.STEP_DIV(8)) u_dut_a (.clk(clk), .rst_n(rst_a), .bus(if_a));
  pac_motion_ctrl #(.STEP_DIV(8), .START_COL(0), .START_ROW(0)) u_dut_b (.clk(clk), .rst_n(rst_b), .bus(if_b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input bit b, input logic [7:0] code);
    @(negedge clk);
    if (b) begin
      if_b.i_ps2_byte  = code;
      if_b.i_ps2_ready = 1'b1;
    end else begin
      if_a.i_ps2_byte  = code;
      if_a.i_ps2_ready = 1'b1;
    end
    @(negedge clk);
    if (b) if_b.i_ps2_ready = 1'b0;
    else if_a.i_ps2_ready = 1'b0;
    @(negedge clk);
  endtask
  task automatic wait_evt(input bit b, output bit s, output bit k);
    s = 1'b0;
    k = 1'b0;
    for (int i = 0; i < 24; i++) begin
      s = b ? if_b.o_step : if_a.o_step;
      k = b ? if_b.o_bump : if_a.o_bump;
      if (s || k) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  task automatic quiet(input bit b, input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (b ? (if_b.o_step | if_b.o_bump) : (if_a.o_step | if_a.o_bump)) c++;
    end
  endtask
  initial begin
    bit s, k;
    int c;
    int i;
    rst_a = 1'b0;
    rst_b = 1'b0;
    if_a.i_ps2_byte = '0; if_a.i_ps2_ready = 1'b0; if_a.i_map_wall = 1'b0;
    if_b.i_ps2_byte = '0; if_b.i_ps2_ready = 1'b0; if_b.i_map_wall = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_px", if_a.o_pac_x, 320);
    check("rst_py", if_a.o_pac_y, 224);
    check("rst_facing", if_a.o_facing, 2);
    check("rst_moving", if_a.o_moving, 0);
    check("rst_step", if_a.o_step, 0);
    check("rst_bump", if_a.o_bump, 0);
    check("rst_addr", if_a.o_map_addr, 0);
    check("rst_b_px", if_b.o_pac_x, 0);
    check("rst_b_py", if_b.o_pac_y, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    quiet(0, 24, c);
    check("nokey_events", c, 0);
    check("nokey_addr", if_a.o_map_addr, 0);
    send(0, 8'hE0);
    send(0, 8'h74);
    check("right_facing", if_a.o_facing, 3);
    check("right_moving", if_a.o_moving, 1);
    wait_evt(0, s, k);
    check("open_step", s, 1);
    check("open_bump", k, 0);
    check("open_addr", if_a.o_map_addr, 151);
    check("open_px", if_a.o_pac_x, 352);
    check("open_py", if_a.o_pac_y, 224);
    if_a.i_map_wall = 1'b1;
    wait_evt(0, s, k);
    check("wall_bump", k, 1);
    check("wall_step", s, 0);
    check("wall_addr", if_a.o_map_addr, 152);
    check("wall_px", if_a.o_pac_x, 352);
    send(0, 8'hE0);
    send(0, 8'hF0);
    send(0, 8'h6B);
    check("brk_other_moving", if_a.o_moving, 1);
    check("brk_other_facing", if_a.o_facing, 3);
    send(0, 8'hE0);
    send(0, 8'hF0);
    send(0, 8'h74);
    check("brk_held_moving", if_a.o_moving, 0);
    repeat (4) @(negedge clk);
    quiet(0, 24, c);
    check("released_events", c, 0);
    check("released_addr", if_a.o_map_addr, 152);
    if_a.i_map_wall = 1'b0;
    send(0, 8'hE0);
    send(0, 8'h72);
    check("down_facing", if_a.o_facing, 1);
    i = 0;
    while (if_a.o_map_addr != 9'd171 && i < 24) begin
      @(negedge clk);
      i++;
    end
    check("down_lookup_addr", if_a.o_map_addr, 171);
    rst_a = 1'b0;
    #1;
    check("midrst_py", if_a.o_pac_y, 224);
    check("midrst_px", if_a.o_pac_x, 320);
    check("midrst_moving", if_a.o_moving, 0);
    check("midrst_addr", if_a.o_map_addr, 0);
    @(negedge clk);
    check("midrst_step", if_a.o_step, 0);
    rst_a = 1'b1;
    quiet(0, 16, c);
    check("midrst_events", c, 0);
    check("midrst_py_after", if_a.o_pac_y, 224);
    check("midrst_moving_after", if_a.o_moving, 0);
    send(1, 8'hE0);
    send(1, 8'h75);
    check("b_up_facing", if_b.o_facing, 0);
    check("b_up_moving", if_b.o_moving, 1);
    wait_evt(1, s, k);
    check("b_up_bump", k, 1);
    check("b_up_step", s, 0);
    check("b_up_addr", if_b.o_map_addr, 0);
    send(1, 8'hE0);
    send(1, 8'h6B);
    check("b_left_facing", if_b.o_facing, 2);
    wait_evt(1, s, k);
    check("b_left_bump", k, 1);
    check("b_left_step", s, 0);
    check("b_left_addr", if_b.o_map_addr, 0);
    check("b_left_px", if_b.o_pac_x, 0);
    check("b_left_py", if_b.o_pac_y, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
